// File: rtl/player_hit_judge.sv
// -----------------------------------------------------------------------------
// player_hit_judge
//
// Decides when an enemy bullet hits the player plane and tracks the player's
// health, lives, invulnerability window, boom (death) window and game-over.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   tick              one-clk frame pulse; the frame timer advances only on it
//   restart           one-clk pulse; leaves OVER and starts a new game
//   pp_x, pp_y        player plane top-left corner
//   eb_x, eb_y        enemy bullet position
//   eb_valid          enemy bullet exists
//   eb_consume        one-clk pulse telling the bullet generator to drop it
//   health, lives     current health and remaining lives
//   invuln, boom,     registered state flags, one-hot with the state
//   game_over         (all zero while ALIVE)
// -----------------------------------------------------------------------------
module player_hit_judge #(
    parameter int HIT_W         = 40,
    parameter int HIT_H         = 40,
    parameter int MAX_HEALTH    = 3,
    parameter int LIVES         = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int BOOM_FRAMES   = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       restart,
    input  logic [9:0] pp_x,
    input  logic [9:0] pp_y,
    input  logic [9:0] eb_x,
    input  logic [9:0] eb_y,
    input  logic       eb_valid,
    output logic       eb_consume,
    output logic [2:0] health,
    output logic [2:0] lives,
    output logic       invuln,
    output logic       boom,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_BOOM   = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] health_q, health_d;
    logic [2:0] lives_q, lives_d;
    logic [7:0] timer_q, timer_d;
    logic       consume_q, consume_d;
    logic       invuln_q, boom_q, over_q;

    // Hitbox far edges are formed at 11 bits so a plane near x/y = 1023
    // does not wrap its box back towards zero.
    logic [10:0] x_end, y_end;
    logic        ov;

    assign x_end = {1'b0, pp_x} + 11'(HIT_W);
    assign y_end = {1'b0, pp_y} + 11'(HIT_H);
    assign ov    = eb_valid
                 & (eb_x >= pp_x) & ({1'b0, eb_x} < x_end)
                 & (eb_y >= pp_y) & ({1'b0, eb_y} < y_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ALIVE;
            health_q  <= 3'(MAX_HEALTH);
            lives_q   <= 3'(LIVES);
            timer_q   <= 8'd0;
            consume_q <= 1'b0;
            invuln_q  <= 1'b0;
            boom_q    <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            health_q  <= health_d;
            lives_q   <= lives_d;
            timer_q   <= timer_d;
            consume_q <= consume_d;
            // Flags track the next state so they change in the same cycle
            // the state does.
            invuln_q  <= (state_d == ST_INVULN);
            boom_q    <= (state_d == ST_BOOM);
            over_q    <= (state_d == ST_OVER);
        end
    end

    always_comb begin
        state_d   = state_q;
        health_d  = health_q;
        lives_d   = lives_q;
        timer_d   = timer_q;
        consume_d = 1'b0;

        // Frame timer counts down on tick; individual states override it.
        if (tick && timer_q != 8'd0) begin
            timer_d = timer_q - 8'd1;
        end

        case (state_q)
            ST_ALIVE: begin
                if (ov) begin
                    consume_d = 1'b1;
                    if (health_q != 3'd0) begin
                        health_d = health_q - 3'd1;
                    end
                    if (health_q <= 3'd1) begin
                        state_d = ST_BOOM;
                        timer_d = 8'(BOOM_FRAMES);
                        if (lives_q != 3'd0) begin
                            lives_d = lives_q - 3'd1;
                        end
                    end else begin
                        state_d = ST_INVULN;
                        timer_d = 8'(INVULN_FRAMES);
                    end
                end
            end
            ST_INVULN: begin
                if (tick && timer_q == 8'd0) begin
                    state_d = ST_ALIVE;
                end
            end
            ST_BOOM: begin
                if (tick && timer_q == 8'd0) begin
                    if (lives_q == 3'd0) begin
                        state_d = ST_OVER;
                    end else begin
                        // Respawn at full health with a fresh grace window.
                        state_d  = ST_INVULN;
                        health_d = 3'(MAX_HEALTH);
                        timer_d  = 8'(INVULN_FRAMES);
                    end
                end
            end
            ST_OVER: begin
                if (restart) begin
                    state_d  = ST_ALIVE;
                    health_d = 3'(MAX_HEALTH);
                    lives_d  = 3'(LIVES);
                    timer_d  = 8'd0;
                end
            end
            default: begin
                state_d = ST_ALIVE;
            end
        endcase
    end

    assign eb_consume = consume_q;
    assign health     = health_q;
    assign lives      = lives_q;
    assign invuln     = invuln_q;
    assign boom       = boom_q;
    assign game_over  = over_q;

endmodule

// File: tb/tb_player_hit_judge.sv
// -----------------------------------------------------------------------------
// tb_player_hit_judge
//
// Directed bench for player_hit_judge: a table of single-hit overlap vectors
// plus hand-written multi-cycle sequences (hold overlap, invulnerability
// expiry, boom/respawn, game over/restart, reset mid-boom).
// -----------------------------------------------------------------------------
module tb_player_hit_judge;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       restart;
    logic [9:0] pp_x, pp_y, eb_x, eb_y;
    logic       eb_valid;
    logic       eb_consume;
    logic [2:0] health, lives;
    logic       invuln, boom, game_over;

    int checks = 0;
    int errors = 0;

    player_hit_judge dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .restart    (restart),
        .pp_x       (pp_x),
        .pp_y       (pp_y),
        .eb_x       (eb_x),
        .eb_y       (eb_y),
        .eb_valid   (eb_valid),
        .eb_consume (eb_consume),
        .health     (health),
        .lives      (lives),
        .invuln     (invuln),
        .boom       (boom),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] ppx;
        logic [9:0] ppy;
        logic [9:0] ebx;
        logic [9:0] eby;
        logic       v;
        logic       hit;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tick     = 1'b0;
        restart  = 1'b0;
        eb_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic set_overlap();
        pp_x = 10'd100; pp_y = 10'd200;
        eb_x = 10'd120; eb_y = 10'd220;
        eb_valid = 1'b1;
    endtask

    // One overlapping cycle from ALIVE; expect the hit to land.
    task automatic hit(input int exp_health, input string name);
        set_overlap();
        step();
        eb_valid = 1'b0;
        check({name, " consume"}, int'(eb_consume), 1);
        check({name, " health"}, int'(health), exp_health);
        $display("hit %s: health=%0d lives=%0d invuln=%0b boom=%0b",
                 name, health, lives, invuln, boom);
    endtask

    // From ALIVE or a fresh INVULN window: three spaced hits ending in BOOM.
    task automatic three_hits(input string name);
        for (int i = 0; i < 3; i++) begin
            ticks(61);
            hit(2 - i, name);
        end
        check({name, " boom"}, int'(boom), 1);
    endtask

    initial begin
        int cnt;
        vecs[0] = '{10'd100, 10'd200, 10'd139, 10'd239, 1'b1, 1'b1};
        vecs[1] = '{10'd100, 10'd200, 10'd140, 10'd200, 1'b1, 1'b0};
        vecs[2] = '{10'd100, 10'd200, 10'd100, 10'd240, 1'b1, 1'b0};
        vecs[3] = '{10'd100, 10'd200, 10'd100, 10'd200, 1'b0, 1'b0};
        vecs[4] = '{10'd100, 10'd200, 10'd100, 10'd200, 1'b1, 1'b1};
        vecs[5] = '{10'd100, 10'd200, 10'd99,  10'd210, 1'b1, 1'b0};
        vecs[6] = '{10'd100, 10'd200, 10'd120, 10'd199, 1'b1, 1'b0};
        vecs[7] = '{10'd1000, 10'd1000, 10'd1023, 10'd1023, 1'b1, 1'b1};

        rst = 1'b1; tick = 1'b0; restart = 1'b0; eb_valid = 1'b0;
        pp_x = '0; pp_y = '0; eb_x = '0; eb_y = '0;

        // Reset and idle hold
        do_reset();
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (eb_consume) cnt++;
        end
        check("reset health", int'(health), 3);
        check("reset lives", int'(lives), 3);
        check("reset invuln", int'(invuln), 0);
        check("reset boom", int'(boom), 0);
        check("reset game_over", int'(game_over), 0);
        check("reset consume pulses", cnt, 0);
        $display("reset: health=%0d lives=%0d", health, lives);

        // Table of single-cycle overlap vectors, each from a fresh reset
        for (int i = 0; i < 8; i++) begin
            do_reset();
            pp_x = vecs[i].ppx; pp_y = vecs[i].ppy;
            eb_x = vecs[i].ebx; eb_y = vecs[i].eby;
            eb_valid = vecs[i].v;
            step();
            check($sformatf("vec%0d consume", i), int'(eb_consume), int'(vecs[i].hit));
            check($sformatf("vec%0d health", i), int'(health), vecs[i].hit ? 2 : 3);
            check($sformatf("vec%0d invuln", i), int'(invuln), int'(vecs[i].hit));
            step();
            check($sformatf("vec%0d consume 2nd", i), int'(eb_consume), 0);
            eb_valid = 1'b0;
            $display("vec%0d: pp=(%0d,%0d) eb=(%0d,%0d) v=%0b consume=%0b health=%0d",
                     i, vecs[i].ppx, vecs[i].ppy, vecs[i].ebx, vecs[i].eby,
                     vecs[i].v, vecs[i].hit, health);
        end

        // Hold overlap 100 clks without tick: one hit only
        do_reset();
        set_overlap();
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (eb_consume) cnt++;
        end
        eb_valid = 1'b0;
        check("hold consume count", cnt, 1);
        check("hold health", int'(health), 2);
        check("hold invuln", int'(invuln), 1);
        $display("hold: consumes=%0d health=%0d", cnt, health);
        ticks(60);
        check("invuln after 60 ticks", int'(invuln), 1);
        ticks(1);
        check("invuln after 61 ticks", int'(invuln), 0);
        hit(1, "post-invuln");
        check("post-invuln invuln", int'(invuln), 1);

        // Three hits to BOOM, then respawn
        do_reset();
        three_hits("boom");
        check("boom health", int'(health), 0);
        check("boom lives", int'(lives), 2);
        check("boom invuln", int'(invuln), 0);
        ticks(30);
        check("boom after 30 ticks", int'(boom), 1);
        ticks(1);
        check("respawn health", int'(health), 3);
        check("respawn invuln", int'(invuln), 1);
        check("respawn boom", int'(boom), 0);
        check("respawn lives", int'(lives), 2);
        // restart outside OVER does nothing
        restart = 1'b1; step(); restart = 1'b0;
        check("restart ignored lives", int'(lives), 2);
        check("restart ignored invuln", int'(invuln), 1);
        $display("respawn: health=%0d lives=%0d", health, lives);

        // Burn remaining lives to game over
        three_hits("life2");
        ticks(31);
        three_hits("life3");
        check("last lives", int'(lives), 0);
        ticks(31);
        check("over flag", int'(game_over), 1);
        check("over health", int'(health), 0);
        check("over boom", int'(boom), 0);
        check("over invuln", int'(invuln), 0);
        set_overlap();
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (eb_consume) cnt++;
        end
        eb_valid = 1'b0;
        check("over consume count", cnt, 0);
        check("over health held", int'(health), 0);
        $display("over: game_over=%0b consumes=%0d", game_over, cnt);
        restart = 1'b1; step(); restart = 1'b0;
        check("restart health", int'(health), 3);
        check("restart lives", int'(lives), 3);
        check("restart game_over", int'(game_over), 0);
        check("restart invuln", int'(invuln), 0);
        $display("restart: health=%0d lives=%0d", health, lives);

        // tick + overlap + restart together while ALIVE
        set_overlap();
        tick = 1'b1; restart = 1'b1;
        step();
        tick = 1'b0; restart = 1'b0; eb_valid = 1'b0;
        check("combo consume", int'(eb_consume), 1);
        check("combo health", int'(health), 2);
        check("combo invuln", int'(invuln), 1);
        check("combo lives", int'(lives), 3);
        $display("combo: health=%0d invuln=%0b", health, invuln);

        // Asynchronous reset in the middle of BOOM
        do_reset();
        three_hits("midboom");
        ticks(10);
        check("midboom still boom", int'(boom), 1);
        rst = 1'b1;
        #1;
        check("async rst health", int'(health), 3);
        check("async rst lives", int'(lives), 3);
        check("async rst boom", int'(boom), 0);
        check("async rst invuln", int'(invuln), 0);
        $display("async reset: health=%0d lives=%0d boom=%0b", health, lives, boom);
        step();
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_hit_judge.md
Name: player_hit_judge

Overview:
Judges enemy-bullet hits on the player plane, the counterpart to the enemy-side hit judge. Each hit costs one health point and consumes the enemy bullet, then grants a timed invulnerability window. When health reaches zero the block runs a boom window, spends one life, and respawns at full health or declares game over. It sits between the enemy bullet generator (consumes `eb_consume`) and the player sprite/HUD renderer (reads `health`, `lives`, `invuln`, `boom`, `game_over`).

Parameters:
HIT_W, 40, player hitbox width in pixels
HIT_H, 40, player hitbox height in pixels
MAX_HEALTH, 3, health loaded at reset and at respawn (1..7)
LIVES, 3, lives loaded at reset and on restart (1..7)
INVULN_FRAMES, 60, tick count of invulnerability after a hit or respawn
BOOM_FRAMES, 30, tick count of boom animation window

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick  in  1  one-clk frame pulse; all frame timers advance only on tick
restart  in  1  one-clk pulse; restarts the game from the OVER state
pp_x  in  10  player plane top-left x
pp_y  in  10  player plane top-left y
eb_x  in  10  enemy bullet x
eb_y  in  10  enemy bullet y
eb_valid  in  1  1 = enemy bullet exists
eb_consume  out  1  one-clk pulse; bullet must be removed
health  out  3  current health
lives  out  3  remaining lives
invuln  out  1  1 while in INVULN (renderer blinks the sprite)
boom  out  1  1 while in BOOM
game_over  out  1  1 while in OVER

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset is legal at any time, including mid-BOOM or mid-INVULN, and forces the reset values below immediately.
  - state=ALIVE, health=MAX_HEALTH, lives=LIVES, timer=0.
  - eb_consume=0, invuln=0, boom=0, game_over=0.
- Overlap (combinational):
  - ov = eb_valid & (eb_x >= pp_x) & (eb_x < pp_x+HIT_W) & (eb_y >= pp_y) & (eb_y < pp_y+HIT_H).
  - Sums are computed at 11 bits so there is no wrap near 1023.
- Timer: 8-bit, decremented only on tick while nonzero.
- ALIVE, on ov:
  - eb_consume=1 on the next clk, for exactly 1 cycle.
  - health -= 1.
  - If health was 1: state -> BOOM, timer=BOOM_FRAMES, lives -= 1 (saturating at 0).
  - Otherwise: state -> INVULN, timer=INVULN_FRAMES.
- INVULN:
  - ov is ignored: no consume, no damage.
  - When timer==0 and tick: state -> ALIVE.
  - If tick and ov occur in the same cycle, only the timer advances.
- BOOM:
  - ov is ignored.
  - When timer==0 and tick: if lives==0, state -> OVER; otherwise health=MAX_HEALTH, state -> INVULN, timer=INVULN_FRAMES (this is the respawn).
- OVER:
  - All hits are ignored and health stays 0.
  - restart -> state=ALIVE, health=MAX_HEALTH, lives=LIVES, timer=0.
  - restart is ignored in every other state.
- Hit timing:
  - One hit is decided per clk.
  - Because a hit always exits ALIVE, a bullet that stays overlapping costs exactly one health point.
  - Hit-to-state latency is 1 clk; eb_consume asserts in the same cycle the new state becomes visible.
- Output encoding: invuln, boom and game_over are registered and exactly one-hot with the state. ALIVE is the state where all three are 0.
- Arithmetic: health and lives never underflow below 0.

Test Plan:
- Reset then hold → health=3, lives=3, all flags 0, eb_consume never pulses.
- Edge overlap: pp=(100,200), eb=(139,239), eb_valid=1 → 1-cycle eb_consume, health=2, invuln=1. Repeat from a fresh reset with eb=(140,200) and with eb=(100,240) → no hit on either.
- Hold the overlap for 100 clks with no tick in INVULN → health stays 2, exactly one eb_consume. Then apply 61 ticks → invuln=0 and the next overlap cycle gives health=1.
- Three hits separated by 61 ticks each → third hit sets boom=1, health=0, lives=2. After 31 ticks → health=3, invuln=1, boom=0.
- Lose all 3 lives → game_over=1 and overlap gives no eb_consume. Then pulse restart → health=3, lives=3, state ALIVE.
- Assert rst mid-BOOM at tick 10 → immediate health=3, lives=3, boom=0. Also assert tick, ov and restart together while ALIVE → the hit is taken and restart is ignored.
